// File: rtl/fwd_pkg.sv
// Shared types and constants for operand forwarding/hazard control.
// Holds the scoreboard entry layout and the special-register decode codes.
package fwd_pkg;

    // Scoreboard destination field is sized for the widest supported register file.
    localparam int SB_AW = 8;

    localparam logic [3:0] SPEC_BUSS   = 4'b0001;
    localparam logic [3:0] SPEC_SHA    = 4'b0010;
    localparam logic [3:0] SPEC_SHB    = 4'b0100;
    localparam logic [3:0] SPEC_PSWCWP = 4'b1000;

    localparam logic [1:0] CODE_BUSS_HI = 2'b10;
    localparam logic [2:0] CODE_SHA     = 3'b011;
    localparam logic [2:0] CODE_SHB     = 3'b010;
    localparam logic [2:0] CODE_PSW     = 3'b111;
    localparam logic [2:0] CODE_CWP     = 3'b110;

    typedef struct packed {
        logic             v;
        logic [SB_AW-1:0] dst;
        logic             ld;
    } sb_entry_t;

    function automatic int fwd_sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Per-operand special decode, youngest-wins forward select and load-use hazard flag.
// Latency: purely combinational.
// Backpressure: none; hazard feeds the issue stall in the parent.
module fwd_src_match
    import fwd_pkg::*;
#(
    parameter int         REG_AW     = 5,
    parameter int         FWD_DEPTH  = 3,
    parameter int         LOAD_LAT   = 1,
    parameter int         NOFWD_ADDR = 16,
    parameter logic [1:0] SPEC_TAG   = 2'b10,
    parameter int         SW         = fwd_sel_w(FWD_DEPTH)
) (
    input  sb_entry_t [FWD_DEPTH:1] sb,
    input  logic [REG_AW-1:0]       src_addr,
    input  logic                    src_used,
    output logic [SW-1:0]           fwd_sel,
    output logic [3:0]              spec_sel,
    output logic                    spec_cwp,
    output logic                    hazard
);

    logic [2:0] lo;
    logic       in_win;
    logic       fwd_ok;

    assign lo     = src_addr[2:0];
    assign in_win = src_used && (src_addr[REG_AW-1 -: 2] == SPEC_TAG);

    always_comb begin
        spec_sel = '0;
        spec_cwp = 1'b0;
        if (in_win) begin
            if (lo[2:1] == CODE_BUSS_HI) begin
                spec_sel = SPEC_BUSS;
            end else begin
                case (lo)
                    CODE_SHA: spec_sel = SPEC_SHA;
                    CODE_SHB: spec_sel = SPEC_SHB;
                    CODE_PSW: spec_sel = SPEC_PSWCWP;
                    CODE_CWP: begin
                        spec_sel = SPEC_PSWCWP;
                        spec_cwp = 1'b1;
                    end
                    default: spec_sel = '0;
                endcase
            end
        end
    end

    assign fwd_ok = src_used && (src_addr != REG_AW'(NOFWD_ADDR)) && (spec_sel == '0);

    // Scan oldest to youngest so the youngest match is the last one written.
    always_comb begin
        fwd_sel = '0;
        hazard  = 1'b0;
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (fwd_ok && sb[k].v && (sb[k].dst == SB_AW'(src_addr))) begin
                fwd_sel = SW'(k);
                hazard  = sb[k].ld && (k <= LOAD_LAT);
            end
        end
    end

endmodule

// File: rtl/operand_fwd_ctrl.sv
// Operand routing and load-use hazard control over a FWD_DEPTH-stage destination scoreboard.
// Latency: outputs combinational from state and issue inputs; scoreboard advances every clock.
// Backpressure: issue_ready low on load-use hazard; FWD_STALL_CNT_EN adds a saturating stall counter.
module operand_fwd_ctrl
    import fwd_pkg::*;
#(
    parameter int         REG_AW     = 5,
    parameter int         NUM_SRC    = 2,
    parameter int         FWD_DEPTH  = 3,
    parameter int         LOAD_LAT   = 1,
    parameter int         NOFWD_ADDR = 16,
    parameter logic [1:0] SPEC_TAG   = 2'b10
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     issue_valid,
    output logic                                     issue_ready,
    input  logic [NUM_SRC*REG_AW-1:0]                src_addr,
    input  logic [NUM_SRC-1:0]                       src_used,
    input  logic [REG_AW-1:0]                        dst_addr,
    input  logic                                     dst_valid,
    input  logic                                     is_load,
    input  logic                                     flush,
    output logic [NUM_SRC*fwd_sel_w(FWD_DEPTH)-1:0]  fwd_sel,
    output logic [NUM_SRC*4-1:0]                     spec_sel,
    output logic [NUM_SRC-1:0]                       spec_cwp
`ifdef FWD_STALL_CNT_EN
    ,
    input  logic                                     stall_cnt_clr,
    output logic [15:0]                              stall_cnt
`endif
);

    localparam int SW = fwd_sel_w(FWD_DEPTH);

    sb_entry_t [FWD_DEPTH:1] sb;
    logic [NUM_SRC-1:0]      hazard;
    logic                    issue_fire;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        fwd_src_match #(
            .REG_AW     (REG_AW),
            .FWD_DEPTH  (FWD_DEPTH),
            .LOAD_LAT   (LOAD_LAT),
            .NOFWD_ADDR (NOFWD_ADDR),
            .SPEC_TAG   (SPEC_TAG),
            .SW         (SW)
        ) u_match (
            .sb       (sb),
            .src_addr (src_addr[gi*REG_AW +: REG_AW]),
            .src_used (src_used[gi]),
            .fwd_sel  (fwd_sel[gi*SW +: SW]),
            .spec_sel (spec_sel[gi*4 +: 4]),
            .spec_cwp (spec_cwp[gi]),
            .hazard   (hazard[gi])
        );
    end

    assign issue_ready = !(issue_valid && (|hazard));
    // Writes to the hardwired register are never tracked.
    assign issue_fire  = issue_valid && issue_ready && dst_valid &&
                         (dst_addr != REG_AW'(NOFWD_ADDR));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb <= '0;
        end else begin
            sb[1].v   <= issue_fire && !flush;
            sb[1].dst <= SB_AW'(dst_addr);
            sb[1].ld  <= is_load;
            for (int k = 2; k <= FWD_DEPTH; k++) begin
                sb[k].v   <= sb[k-1].v && !flush;
                sb[k].dst <= sb[k-1].dst;
                sb[k].ld  <= sb[k-1].ld;
            end
        end
    end

`ifdef FWD_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall_cnt_clr) begin
            stall_cnt <= '0;
        end else if (issue_valid && !issue_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`else
    // Stall counter omitted in this build.
`endif

endmodule

// File: tb/tb_operand_fwd_ctrl.sv
// Bench for operand_fwd_ctrl: directed vector table, counter/reset sequences, then random
// traffic against a queue-based reference of in-flight writers.
module tb_operand_fwd_ctrl;

    localparam int AW = 5;
    localparam int NS = 2;
    localparam int D  = 3;
    localparam int LL = 1;
    localparam int SW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             issue_valid;
    logic             issue_ready;
    logic [NS*AW-1:0] src_addr;
    logic [NS-1:0]    src_used;
    logic [AW-1:0]    dst_addr;
    logic             dst_valid;
    logic             is_load;
    logic             flush;
    logic [NS*SW-1:0] fwd_sel;
    logic [NS*4-1:0]  spec_sel;
    logic [NS-1:0]    spec_cwp;
`ifdef FWD_STALL_CNT_EN
    logic             stall_cnt_clr;
    logic [15:0]      stall_cnt;
`endif

    operand_fwd_ctrl #(
        .REG_AW(AW), .NUM_SRC(NS), .FWD_DEPTH(D), .LOAD_LAT(LL),
        .NOFWD_ADDR(16), .SPEC_TAG(2'b10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .src_addr    (src_addr),
        .src_used    (src_used),
        .dst_addr    (dst_addr),
        .dst_valid   (dst_valid),
        .is_load     (is_load),
        .flush       (flush),
        .fwd_sel     (fwd_sel),
        .spec_sel    (spec_sel),
        .spec_cwp    (spec_cwp)
`ifdef FWD_STALL_CNT_EN
        ,
        .stall_cnt_clr (stall_cnt_clr),
        .stall_cnt     (stall_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit v;
        int dst;
        bit ld;
    } ent_t;

    // Index 0 is the youngest in-flight instruction (stage 1).
    ent_t q[$];
    bit   m_ready;
    bit   m_haz[NS];
    int   m_fwd[NS];
    int   m_spec[NS];
    int   m_cwp[NS];
    int   m_cnt;

    typedef struct {
        int iv, s0, s1, used, dv, dst, ld, fl;
        int rdy, f0, f1, sp0, sp1, cwp0;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Special window is addresses 16..23; offset inside the window picks the target.
    function automatic void spec_ref(input int a, input bit used, output int sel, output int cwp);
        sel = 0;
        cwp = 0;
        if (used && a >= 16 && a <= 23) begin
            case (a - 16)
                4, 5: sel = 1;
                3:    sel = 2;
                2:    sel = 4;
                7:    sel = 8;
                6:    begin sel = 8; cwp = 1; end
                default: sel = 0;
            endcase
        end
    endfunction

    task automatic model_reset();
        ent_t e;
        e.v = 0; e.dst = 0; e.ld = 0;
        q.delete();
        for (int j = 0; j < D; j++) q.push_back(e);
        m_cnt = 0;
    endtask

    task automatic model_eval();
        int a;
        for (int i = 0; i < NS; i++) begin
            a = int'(src_addr[i*AW +: AW]);
            spec_ref(a, src_used[i], m_spec[i], m_cwp[i]);
            m_fwd[i] = 0;
            m_haz[i] = 0;
            if (src_used[i] && a != 16 && m_spec[i] == 0) begin
                for (int j = 0; j < q.size(); j++) begin
                    if (q[j].v && q[j].dst == a) begin
                        m_fwd[i] = j + 1;
                        m_haz[i] = q[j].ld && (j + 1 <= LL);
                        break;
                    end
                end
            end
        end
        m_ready = !(issue_valid && (m_haz[0] || m_haz[1]));
    endtask

    task automatic model_commit();
        ent_t e;
`ifdef FWD_STALL_CNT_EN
        if (stall_cnt_clr) m_cnt = 0;
        else if (issue_valid && !m_ready && m_cnt < 65535) m_cnt++;
`endif
        if (flush) begin
            for (int j = 0; j < q.size(); j++) q[j].v = 0;
        end
        e.v   = issue_valid && m_ready && dst_valid && (int'(dst_addr) != 16) && !flush;
        e.dst = int'(dst_addr);
        e.ld  = is_load;
        q.push_front(e);
        while (q.size() > D) void'(q.pop_back());
    endtask

    task automatic drive(input int iv, input int s0, input int s1, input int used,
                         input int dv, input int dst, input int ld, input int fl);
        issue_valid = iv[0];
        src_addr    = {AW'(s1), AW'(s0)};
        src_used    = NS'(used);
        dst_valid   = dv[0];
        dst_addr    = AW'(dst);
        is_load     = ld[0];
        flush       = fl[0];
    endtask

    task automatic eval_cycle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic end_cycle();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int iv, input int s0, input int s1, input int used, input int dv,
                       input int dst, input int ld, input int fl, input int rdy, input int f0,
                       input int f1, input int sp0, input int sp1, input int cwp0);
        vec_t v;
        v.iv = iv; v.s0 = s0; v.s1 = s1; v.used = used; v.dv = dv; v.dst = dst;
        v.ld = ld; v.fl = fl; v.rdy = rdy; v.f0 = f0; v.f1 = f1;
        v.sp0 = sp0; v.sp1 = sp1; v.cwp0 = cwp0;
        tbl.push_back(v);
    endtask

    function automatic int rnd_addr();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(16, 23));
        return int'($urandom_range(0, 7));
    endfunction

    initial begin
        // iv s0 s1 used dv dst ld fl | rdy f0 f1 sp0 sp1 cwp0  (-1 = not checked)
        add(1,  3,  7, 3, 0,  0, 0, 0,  1,  0,  0, 0, 0, 0);
        add(1,  3,  7, 3, 1,  5, 0, 0,  1,  0,  0, 0, 0, 0);
        add(1,  5,  0, 1, 0,  0, 0, 0,  1,  1,  0, 0, 0, 0);
        add(0,  5,  0, 1, 0,  0, 0, 0,  1,  2,  0, 0, 0, 0);
        add(0,  5,  0, 1, 0,  0, 0, 0,  1,  3,  0, 0, 0, 0);
        add(0,  5,  0, 1, 0,  0, 0, 0,  1,  0,  0, 0, 0, 0);
        add(1,  0,  0, 0, 1,  9, 1, 0,  1,  0,  0, 0, 0, 0);
        add(1,  0,  9, 2, 0,  0, 0, 0,  0,  0, -1, 0, 0, 0);
        add(1,  0,  9, 2, 0,  0, 0, 0,  1,  0,  2, 0, 0, 0);
        add(1,  0,  0, 0, 1,  4, 1, 0,  1,  0,  0, 0, 0, 0);
        add(1,  0,  0, 0, 1,  4, 0, 0,  1,  0,  0, 0, 0, 0);
        add(1,  4,  0, 1, 0,  0, 0, 0,  1,  1,  0, 0, 0, 0);
        add(1,  0,  0, 0, 1, 16, 0, 0,  1,  0,  0, 0, 0, 0);
        add(1, 16,  0, 1, 0,  0, 0, 0,  1,  0,  0, 0, 0, 0);
        add(1,  0,  0, 0, 1, 23, 0, 0,  1,  0,  0, 0, 0, 0);
        add(1, 23,  0, 1, 0,  0, 0, 0,  1,  0,  0, 8, 0, 0);
        add(1, 22,  0, 1, 0,  0, 0, 0,  1,  0,  0, 8, 0, 1);
        add(1, 19, 18, 3, 0,  0, 0, 0,  1,  0,  0, 2, 4, 0);
        add(1, 21, 20, 3, 0,  0, 0, 0,  1,  0,  0, 1, 1, 0);
        add(1, 23, 17, 2, 0,  0, 0, 0,  1,  0,  0, 0, 0, 0);
        add(1,  0,  0, 0, 1,  2, 1, 0,  1,  0,  0, 0, 0, 0);
        add(1,  0,  0, 0, 1,  6, 0, 1,  1,  0,  0, 0, 0, 0);
        add(1,  2,  6, 3, 0,  0, 0, 0,  1,  0,  0, 0, 0, 0);
        add(1,  0,  0, 0, 1,  2, 1, 0,  1,  0,  0, 0, 0, 0);
        add(1,  2,  0, 1, 0,  0, 0, 1,  0, -1,  0, 0, 0, 0);
        add(1,  2,  0, 1, 0,  0, 0, 0,  1,  0,  0, 0, 0, 0);

        rst_n = 1'b0;
`ifdef FWD_STALL_CNT_EN
        stall_cnt_clr = 1'b0;
`endif
        drive(1, 21, 3, 3, 0, 0, 0, 0);
        #3;
        chk("rst_ready", int'(issue_ready), 1);
        chk("rst_fwd", int'(fwd_sel), 0);
        chk("rst_spec", int'(spec_sel), 1);
`ifdef FWD_STALL_CNT_EN
        chk("rst_cnt", int'(stall_cnt), 0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;

        for (int r = 0; r < tbl.size(); r++) begin
            drive(tbl[r].iv, tbl[r].s0, tbl[r].s1, tbl[r].used,
                  tbl[r].dv, tbl[r].dst, tbl[r].ld, tbl[r].fl);
            eval_cycle();
            chk($sformatf("t%0d_ready", r), int'(issue_ready), tbl[r].rdy);
            if (tbl[r].f0 >= 0) chk($sformatf("t%0d_fwd0", r), int'(fwd_sel[SW-1:0]), tbl[r].f0);
            if (tbl[r].f1 >= 0) chk($sformatf("t%0d_fwd1", r), int'(fwd_sel[2*SW-1:SW]), tbl[r].f1);
            chk($sformatf("t%0d_spec0", r), int'(spec_sel[3:0]), tbl[r].sp0);
            chk($sformatf("t%0d_spec1", r), int'(spec_sel[7:4]), tbl[r].sp1);
            chk($sformatf("t%0d_cwp0", r), int'(spec_cwp[0]), tbl[r].cwp0);
            end_cycle();
        end

`ifdef FWD_STALL_CNT_EN
        stall_cnt_clr = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        eval_cycle();
        end_cycle();
        stall_cnt_clr = 1'b0;
        for (int n = 0; n < 3; n++) begin
            drive(1, 0, 0, 0, 1, 9, 1, 0); eval_cycle(); end_cycle();
            drive(1, 9, 0, 1, 0, 0, 0, 0); eval_cycle(); end_cycle();
            drive(1, 9, 0, 1, 0, 0, 0, 0); eval_cycle(); end_cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        eval_cycle();
        chk("cnt_three", int'(stall_cnt), 3);
        end_cycle();
        drive(1, 0, 0, 0, 1, 9, 1, 0); eval_cycle(); end_cycle();
        stall_cnt_clr = 1'b1;
        drive(1, 9, 0, 1, 0, 0, 0, 0);
        eval_cycle();
        chk("cnt_stall_with_clr_ready", int'(issue_ready), 0);
        end_cycle();
        stall_cnt_clr = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        eval_cycle();
        chk("cnt_clr", int'(stall_cnt), 0);
        end_cycle();
`endif

        // Asynchronous reset in the middle of traffic wipes a pending load.
        drive(1, 0, 0, 0, 1, 9, 1, 0);
        eval_cycle();
        end_cycle();
        drive(1, 9, 0, 1, 0, 0, 0, 0);
        #1;
        chk("midrst_pre_ready", int'(issue_ready), 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", int'(issue_ready), 1);
        chk("midrst_fwd0", int'(fwd_sel[SW-1:0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        #1;

        for (int c = 0; c < 600; c++) begin
            drive(($urandom_range(0, 4) != 0) ? 1 : 0, rnd_addr(), rnd_addr(),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), rnd_addr(),
                  ($urandom_range(0, 2) == 0) ? 1 : 0, ($urandom_range(0, 19) == 0) ? 1 : 0);
`ifdef FWD_STALL_CNT_EN
            stall_cnt_clr = ($urandom_range(0, 39) == 0);
`endif
            eval_cycle();
            chk($sformatf("r%0d_ready", c), int'(issue_ready), int'(m_ready));
            for (int i = 0; i < NS; i++) begin
                if (!m_haz[i])
                    chk($sformatf("r%0d_fwd%0d", c, i), int'(fwd_sel[i*SW +: SW]), m_fwd[i]);
                chk($sformatf("r%0d_spec%0d", c, i), int'(spec_sel[i*4 +: 4]), m_spec[i]);
                chk($sformatf("r%0d_cwp%0d", c, i), int'(spec_cwp[i]), m_cwp[i]);
            end
`ifdef FWD_STALL_CNT_EN
            chk($sformatf("r%0d_cnt", c), int'(stall_cnt), m_cnt);
`endif
            end_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
